// File: rtl/divider_gen.sv
// Iterative restoring divider: one quotient bit per cycle, signed or unsigned,
// with single-cycle shortcuts for divide-by-zero and signed MIN / -1.
module divider_gen #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic             flush,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             valid,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dsr;
   logic [WIDTH-1:0] prem;
   logic             q_neg;
   logic             r_neg;
   logic             dz_pend;
   logic             ov_pend;

   logic             accept;
   logic             dvd_neg;
   logic             dsr_neg;
   logic             dsr_zero;
   logic             ovf_case;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dsr_mag;
   logic [WIDTH-1:0] min_val;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   diff;

   // Operand conditioning and the (WIDTH+1)-bit trial subtract
   always_comb begin
      min_val   = {1'b1, {(WIDTH-1){1'b0}}};
      accept    = start & ~flush & (state == IDLE);
      dvd_neg   = is_signed & dividend[WIDTH-1];
      dsr_neg   = is_signed & divisor[WIDTH-1];
      dvd_mag   = dvd_neg ? -dividend : dividend;
      dsr_mag   = dsr_neg ? -divisor : divisor;
      dsr_zero  = (divisor == '0);
      ovf_case  = is_signed & (dividend == min_val) & (divisor == '1);
      rem_shift = {prem, dvd_q[WIDTH-1]};
      diff      = rem_shift - {1'b0, dsr};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         dvd_q       <= '0;
         dsr         <= '0;
         prem        <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         dz_pend     <= 1'b0;
         ov_pend     <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         valid       <= 1'b0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (flush && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (accept) begin
                     busy    <= 1'b1;
                     cnt     <= '0;
                     prem    <= '0;
                     dsr     <= dsr_mag;
                     q_neg   <= dvd_neg ^ dsr_neg;
                     r_neg   <= dvd_neg;
                     dz_pend <= dsr_zero;
                     ov_pend <= ovf_case & ~dsr_zero;
                     // Divide-by-zero keeps the raw dividend for the remainder
                     dvd_q   <= dsr_zero ? dividend : dvd_mag;
                     state   <= (dsr_zero || ovf_case) ? DONE : CALC;
                  end
               end
               CALC: begin
                  if (!diff[WIDTH]) begin
                     prem  <= diff[WIDTH-1:0];
                     dvd_q <= {dvd_q[WIDTH-2:0], 1'b1};
                  end else begin
                     prem  <= rem_shift[WIDTH-1:0];
                     dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                  end
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(WIDTH - 1)) state <= DONE;
               end
               DONE: begin
                  valid       <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
                  div_by_zero <= dz_pend;
                  overflow    <= ov_pend;
                  if (dz_pend) begin
                     quotient  <= '1;
                     remainder <= dvd_q;
                  end else if (ov_pend) begin
                     quotient  <= min_val;
                     remainder <= '0;
                  end else begin
                     quotient  <= q_neg ? -dvd_q : dvd_q;
                     remainder <= r_neg ? -prem : prem;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_divider_gen.sv
// Directed self-checking bench for divider_gen at WIDTH=32.
module tb_divider_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_signed;
   logic        flush;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        busy;
   logic        valid;
   logic        div_by_zero;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   divider_gen #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .flush(flush),
      .dividend(dividend), .divisor(divisor), .quotient(quotient),
      .remainder(remainder), .busy(busy), .valid(valid),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present an operation and consume the accept edge
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
      dividend  = a;
      divisor   = b;
      is_signed = s;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("accept_busy", 64'(busy), 64'(1));
      check("accept_valid", 64'(valid), 64'(0));
   endtask

   // Wait (bounded) for valid and compare latency, results and flags
   task automatic wait_result(input string tag, input int exp_lat,
                              input logic [31:0] q, input logic [31:0] r,
                              input logic dz, input logic ov);
      int lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (valid) begin
            lat = i;
            break;
         end
      end
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_q"}, 64'(quotient), 64'(q));
      check({tag, "_r"}, 64'(remainder), 64'(r));
      check({tag, "_dz"}, 64'(div_by_zero), 64'(dz));
      check({tag, "_ov"}, 64'(overflow), 64'(ov));
      check({tag, "_busy"}, 64'(busy), 64'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      rst = 1'b1; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
      dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_q", 64'(quotient), 64'(0));
      check("rst_r", 64'(remainder), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_valid", 64'(valid), 64'(0));
      check("rst_flags", 64'({div_by_zero, overflow}), 64'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      launch(32'd100, 32'd7, 1'b0);
      wait_result("u100_7", 33, 32'd14, 32'd2, 1'b0, 1'b0);
      launch(32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_result("s-7_2", 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
      launch(32'd7, 32'hFFFF_FFFE, 1'b1);
      wait_result("s7_-2", 33, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
      launch(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1);
      wait_result("s-7_-2", 33, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);
      launch(32'hFFFF_FFFF, 32'd1, 1'b0);
      wait_result("uffff_1", 33, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);

      launch(32'd5, 32'd0, 1'b0);
      wait_result("u5_0", 1, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
      launch(32'd5, 32'd0, 1'b1);
      wait_result("s5_0", 1, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
      launch(32'hFFFF_FFFB, 32'd0, 1'b1);
      wait_result("s-5_0", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0);

      launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_result("s_ovf", 1, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
      launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      wait_result("u_min_ff", 33, 32'd0, 32'h8000_0000, 1'b0, 1'b0);

      // Start while busy must not disturb the running 100/7
      launch(32'd100, 32'd7, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      dividend = 32'd9; divisor = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_result("busy_start", 29, 32'd14, 32'd2, 1'b0, 1'b0);

      // Flush 10 cycles after accept, with a competing start
      launch(32'd1000, 32'd3, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1; start = 1'b1; dividend = 32'd9; divisor = 32'd3;
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0;
      check("flush_busy", 64'(busy), 64'(0));
      check("flush_valid", 64'(valid), 64'(0));
      check("flush_q", 64'(quotient), 64'(14));
      check("flush_r", 64'(remainder), 64'(2));
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (valid || busy) cnt++;
      end
      check("flush_quiet", 64'(cnt), 64'(0));

      // Flush and start together while idle: start must lose
      flush = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0;
      check("idle_flush_start_busy", 64'(busy), 64'(0));
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (valid || busy) cnt++;
      end
      check("idle_flush_quiet", 64'(cnt), 64'(0));

      // Reset mid-CALC with non-zero prior results and flags
      launch(32'd5, 32'd0, 1'b0);
      wait_result("pre_rst", 1, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
      launch(32'd100, 32'd7, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_q", 64'(quotient), 64'(0));
      check("mid_rst_r", 64'(remainder), 64'(0));
      check("mid_rst_busy", 64'(busy), 64'(0));
      check("mid_rst_valid", 64'(valid), 64'(0));
      check("mid_rst_flags", 64'({div_by_zero, overflow}), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_busy", 64'(busy), 64'(0));
      check("post_rst_valid", 64'(valid), 64'(0));

      // Back-to-back: second start in the cycle valid is high
      launch(32'd100, 32'd7, 1'b0);
      wait_result("b2b_1", 33, 32'd14, 32'd2, 1'b0, 1'b0);
      launch(32'd9, 32'd3, 1'b0);
      wait_result("b2b_2", 33, 32'd3, 32'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("valid_pulse_end", 64'(valid), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
